// File: rtl/byte_word_packer.sv
// Packs an 8-bit byte stream into 32-bit words on a valid/ready interface.
// A completed word waits in the assembly register (S_FULL) while the output register is stalled.
module byte_word_packer #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic [2:0]  out_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] acc;
  logic [1:0]  idx;

  logic        out_free;
  logic        byte_acc;
  logic        complete;
  logic        load_out;
  logic [4:0]  shift;
  logic [31:0] merged;
  logic [31:0] load_word;
  logic [2:0]  load_bytes;

  assign in_ready = (state != S_FULL);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    out_free   = !out_valid || out_ready;
    byte_acc   = in_valid && in_ready;
    complete   = byte_acc && ((idx == 2'd3) || in_last);
    shift      = BIG_ENDIAN ? {~idx, 3'b000} : {idx, 3'b000};
    merged     = acc | ({24'd0, in_data} << shift);
    load_out   = out_free && (complete || (state == S_FULL));
    load_word  = (state == S_FULL) ? acc : merged;
    // In S_FULL idx still holds the index of the completing byte.
    load_bytes = {1'b0, idx} + 3'd1;

    state_nx = state;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (complete)      state_nx = out_free ? S_IDLE : S_FULL;
        else if (byte_acc) state_nx = S_COLLECT;
      end
      S_FULL: begin
        if (out_free) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      idx <= '0;
    end else if (load_out) begin
      acc <= '0;
      idx <= '0;
    end else if (complete) begin
      acc <= merged;
    end else if (byte_acc) begin
      acc <= merged;
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_word   <= '0;
      out_bytes  <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      if (load_out) begin
        out_word  <= load_word;
        out_bytes <= load_bytes;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and randomized checks of byte_word_packer in both byte orders, driven side by side
// with identical stimulus and compared against a packet-level reference model.
module tb_byte_word_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        le_in_ready, be_in_ready;
  logic [31:0] le_word, be_word;
  logic [2:0]  le_bytes, be_bytes;
  logic        le_valid, be_valid;
  logic [15:0] le_wc, be_wc;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0][7:0] b;
    logic [2:0]      n;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t cur;
  pkt_t p;
  int   exp_wc;
  int   drops;

  byte_word_packer #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(le_in_ready), .out_word(le_word), .out_bytes(le_bytes), .out_valid(le_valid),
    .out_ready(out_ready), .word_count(le_wc)
  );

  byte_word_packer #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(be_in_ready), .out_word(be_word), .out_bytes(be_bytes), .out_valid(be_valid),
    .out_ready(out_ready), .word_count(be_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();
  endtask

  // Reference packing: byte k goes to lane k (little) or lane 3-k (big).
  function automatic logic [31:0] pack(input pkt_t pk, input bit be);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(pk.n)) w = w | ({24'd0, pk.b[k]} << (be ? (24 - 8 * k) : (8 * k)));
    return w;
  endfunction

  task automatic check_both_idle(input string tag);
    check({tag, "_valid_le"}, le_valid, 1'b0);
    check({tag, "_valid_be"}, be_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("async_reset_valid", le_valid, 1'b0);

    // Reset state
    do_reset();
    check("rst_out_word", le_word, 32'h0);
    check("rst_out_bytes", le_bytes, 3'd0);
    check("rst_word_count", le_wc, 16'd0);
    check("rst_in_ready", le_in_ready, 1'b1);
    check_both_idle("rst");

    // Full word, both byte orders
    out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("w1_valid", le_valid, 1'b1);
    check("w1_le_word", le_word, 32'h44332211);
    check("w1_be_word", be_word, 32'h11223344);
    check("w1_bytes", le_bytes, 3'd4);
    check("w1_be_bytes", be_bytes, 3'd4);
    check("w1_wc_before", le_wc, 16'd0);
    tick();
    check_both_idle("w1_drained");
    check("w1_wc", le_wc, 16'd1);
    exp_wc = 1;

    // Short packet flushed by in_last
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("last_le_word", le_word, 32'h0000BBAA);
    check("last_be_word", be_word, 32'hAABB0000);
    check("last_bytes", le_bytes, 3'd2);
    check("last_in_ready", le_in_ready, 1'b1);
    tick();
    exp_wc++;
    check("last_wc", le_wc, 16'(exp_wc));

    // Backpressure: eight bytes with out_ready low
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("bp_in_ready_b%0d", i), le_in_ready, 1'b1);
      send(8'(i), 1'b0);
    end
    check("bp_full_in_ready", le_in_ready, 1'b0);
    check("bp_full_be_in_ready", be_in_ready, 1'b0);
    check("bp_hold_word", le_word, 32'h04030201);
    check("bp_hold_valid", le_valid, 1'b1);
    tick();
    check("bp_stall_word", le_word, 32'h04030201);
    check("bp_stall_bytes", le_bytes, 3'd4);
    check("bp_stall_in_ready", le_in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    exp_wc++;
    check("bp_w2_le_word", le_word, 32'h08070605);
    check("bp_w2_be_word", be_word, 32'h05060708);
    check("bp_w2_valid", le_valid, 1'b1);
    check("bp_release_in_ready", le_in_ready, 1'b1);
    check("bp_wc_1", le_wc, 16'(exp_wc));
    tick();
    exp_wc++;
    check_both_idle("bp_drained");
    check("bp_wc_2", le_wc, 16'(exp_wc));

    // Reset in the middle of a packet, with a word stalled on the output
    out_ready = 1'b0;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b0);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    check("mid_pre_valid", le_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", le_valid, 1'b0);
    check("mid_rst_word", le_word, 32'h0);
    check("mid_rst_bytes", le_bytes, 3'd0);
    check("mid_rst_wc", le_wc, 16'd0);
    check("mid_rst_in_ready", le_in_ready, 1'b1);
    #3 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_both_idle($sformatf("mid_post_%0d", i));
    end
    send(8'hDD, 1'b1);
    check("mid_fresh_le_word", le_word, 32'h000000DD);
    check("mid_fresh_be_word", be_word, 32'hDD000000);
    check("mid_fresh_bytes", le_bytes, 3'd1);

    // Randomized traffic against the packet-level model
    do_reset();
    exp_q.delete();
    cur    = '0;
    exp_wc = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      // Words in flight are those on the output plus at most one held in assembly.
      check("rnd_out_valid", le_valid, exp_q.size() > 0);
      check("rnd_in_ready", le_in_ready, exp_q.size() < 2);
      if (le_valid && out_ready) begin
        check("rnd_word_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("rnd_le_word", le_word, pack(p, 1'b0));
          check("rnd_be_word", be_word, pack(p, 1'b1));
          check("rnd_bytes", le_bytes, p.n);
          exp_wc++;
        end
      end
      if (in_valid && le_in_ready) begin
        cur.b[cur.n[1:0]] = in_data;
        cur.n = cur.n + 3'd1;
        if (cur.n == 3'd4 || in_last) begin
          exp_q.push_back(cur);
          cur = '0;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && le_valid; c++) begin
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        check("drain_le_word", le_word, pack(p, 1'b0));
        exp_wc++;
      end
      tick();
    end
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_valid_after_drain", le_valid, 1'b0);
    check("rnd_wc", le_wc, 16'(exp_wc));
    check("rnd_be_wc", be_wc, 16'(exp_wc));

    // Sustained single-byte packets across the word_count wrap
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    drops     = 0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 8'((i + 1) * 3);
      if (!le_in_ready || !be_in_ready) drops++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("wrap_no_drops", drops, 0);
    check("wrap_pre_wc", le_wc, 16'd0);
    check("wrap_last_le_word", le_word, 32'h00000003);
    check("wrap_last_be_word", be_word, 32'h03000000);
    check("wrap_last_bytes", le_bytes, 3'd1);
    tick();
    check("wrap_wc", le_wc, 16'd1);
    check("wrap_be_wc", be_wc, 16'd1);
    check_both_idle("wrap_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
